modport_mem: RTL and testbench



---
 rtl/modport_mem.sv | 72 +++++++
 tb/tb_modport_mem.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/modport_mem.sv
// -----------------------------------------------------------------------------
// modport_mem
//
// Small register-file memory of 2**ADDR_WIDTH words, each DATA_WIDTH bits
// wide. One command port: a write and/or a read are issued in the same cycle
// and qualified by valid. Read data is registered and appears one cycle after
// the read command.
//
// Ports:
//   clk    - rising-edge clock, the only clock
//   reset  - synchronous, active-high reset; clears every word and rdata
//   addr   - word address shared by the read and the write command
//   wr_en  - write command (ignored while valid is low)
//   rd_en  - read command (ignored while valid is low)
//   wdata  - write data
//   valid  - command qualifier
//   rdata  - registered read data; holds its value between reads
// -----------------------------------------------------------------------------
module modport_mem #(
  parameter int                    ADDR_WIDTH  = 2,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  valid,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage lives in flops rather than a RAM macro so every word can be
  // cleared by reset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_write;
  logic w_read;

  assign w_write = valid & wr_en;
  assign w_read  = valid & rd_en;

  // Memory array. Reset wins over any command presented in the same cycle,
  // so a write coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= RESET_VALUE;
      end
    end else if (w_write) begin
      r_mem[addr] <= wdata;
    end
  end

  // Read data register. Because the array update above is non-blocking, a
  // read sampling the same address as a same-edge write returns the old word
  // (read-before-write). With no read command the register simply holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= RESET_VALUE;
    end else if (w_read) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: tb/tb_modport_mem.sv
// -----------------------------------------------------------------------------
// tb_modport_mem
//
// Self-checking bench for modport_mem. A behavioural model of four words and
// the expected read register is updated once per clock from the command that
// was applied; a compare process checks rdata against it every cycle, and a
// set of directed checks pins both the DUT and the model to literal values.
// A randomized 1000-command mix finishes the run.
// -----------------------------------------------------------------------------
module tb_modport_mem;

  logic       clk;
  logic       reset;
  logic [1:0] addr;
  logic       wrEn;
  logic       rdEn;
  logic [7:0] wdata;
  logic       valid;
  logic [7:0] rdata;

  // Behavioural model state
  logic [7:0] modelMem [4];
  logic [7:0] expRdata;
  logic       checkEnable;

  int assertCount;
  int failCount;

  modport_mem #(
    .ADDR_WIDTH (2),
    .DATA_WIDTH (8),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wr_en(wrEn),
    .rd_en(rdEn),
    .wdata(wdata),
    .valid(valid),
    .rdata(rdata)
  );

  // 10-unit clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one command, let one rising edge consume it, then advance the model
  // by the same rules the memory must obey, and return 1 unit after the edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic w,
                               input logic r, input logic [1:0] a,
                               input logic [7:0] d);
    logic [7:0] oldWord;
    reset = rst;
    valid = v;
    wrEn  = w;
    rdEn  = r;
    addr  = a;
    wdata = d;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) modelMem[i] = 8'h00;
      expRdata    = 8'h00;
      checkEnable = 1'b1;
    end else begin
      oldWord = modelMem[a];
      if (v && w) modelMem[a] = d;
      if (v && r) expRdata = oldWord;
    end
    #1;
  endtask

  // Directed check against a hand-computed literal; also pins the model.
  task automatic checkOutput(input string name, input logic [7:0] expected);
    assertCount++;
    if (rdata !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: rdata=%h expected=%h", name, rdata, expected);
    end
    assertCount++;
    if (expRdata !== expected) begin
      failCount++;
      $display("[TB] FAIL %s_model: model=%h expected=%h", name, expRdata, expected);
    end
  endtask

  // Continuous comparison against the model, half a cycle after each edge.
  always @(negedge clk) begin
    if (checkEnable) begin
      assertCount++;
      if (rdata !== expRdata) begin
        failCount++;
        $display("[TB] FAIL cycleCompare @%0t: rdata=%h expected=%h",
                 $time, rdata, expRdata);
      end
    end
  end

  initial begin
    logic       rndRst;
    logic       rndValid;
    logic       rndWr;
    logic       rndRd;
    logic [1:0] rndAddr;
    logic [7:0] rndData;

    assertCount = 0;
    failCount   = 0;
    checkEnable = 1'b0;
    expRdata    = 8'h00;
    for (int i = 0; i < 4; i++) modelMem[i] = 8'h00;

    $display("[TB] Reset held for two cycles");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    checkOutput("resetRdata", 8'h00);
    for (int a = 0; a < 4; a++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'(a), 8'h00);
      checkOutput("resetRead", 8'h00);
    end

    $display("[TB] Write then back-to-back readback");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hA5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'h00);
    checkOutput("readAddr3", 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 8'h00);
    checkOutput("readAddr2", 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h00);
    checkOutput("readAddr1", 8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
    checkOutput("readAddr0", 8'hA5);

    $display("[TB] Commands with valid low are ignored");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'h77);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h00);
    checkOutput("unqualifiedWrite", 8'h3C);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    checkOutput("unqualifiedRead", 8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 8'h99);
    checkOutput("idleHold", 8'h3C);

    $display("[TB] Simultaneous read and write to one address");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'h5A);
    checkOutput("readBeforeWrite", 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 8'h00);
    checkOutput("writeLanded", 8'h5A);

    $display("[TB] Reset in the middle of traffic");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hA5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'h00);
    checkOutput("readBeforeReset", 8'h01);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h11);
    checkOutput("rdataAfterReset", 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
    checkOutput("writeLostInReset", 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'hC3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h00);
    checkOutput("writeAfterReset", 8'hC3);

    $display("[TB] Randomized 1000-command mix");
    for (int n = 0; n < 1000; n++) begin
      rndRst   = ($urandom_range(63, 0) == 0);
      rndValid = ($urandom_range(7, 0) != 0);
      rndWr    = 1'($urandom_range(1, 0));
      rndRd    = 1'($urandom_range(1, 0));
      rndAddr  = 2'($urandom_range(3, 0));
      rndData  = 8'($urandom_range(255, 0));
      applyStimulus(rndRst, rndValid, rndWr, rndRd, rndAddr, rndData);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
